// File: rtl/ex_muldiv_unit_if.sv
// Handshake bundle between ID/MEM and the M-extension execute unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [4:0]      in_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            busy;

  // Unit side
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, busy
  );

  // Pipeline side (ID issue, MEM drain, branch/interrupt cancel)
  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32 M-extension execute unit: pipelined multiply, restoring divide,
// one op at a time, result held until MEM accepts it.
module ex_muldiv_unit #(
  parameter int XLEN         = 32,
  parameter int MUL_STAGES   = 2,
  parameter int DIV_FASTPATH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;
  // product chain depth; the first stage is written at accept
  localparam int PS = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam logic [CW-1:0]   MUL_LAST = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [2:0]              r_op;
  logic [4:0]              r_rd;
  logic [CW-1:0]           r_cnt;
  logic [XLEN-1:0]         r_result;
  logic [PS-1:0][PW-1:0]   r_prod;
  logic [XLEN-1:0]         r_q;     // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]         r_rem;
  logic [XLEN-1:0]         r_dvs;
  logic                    r_neg_q, r_neg_r;

  // Accept-side decode
  logic            w_accept, w_is_div, w_sdiv, w_b_zero, w_ovf, w_fast;
  logic            w_a_neg, w_b_neg, w_msa, w_msb;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;
  logic [PW-1:0]   w_a_x, w_b_x, w_prod;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_is_div = bus.in_op[2];
  assign w_sdiv   = ~bus.in_op[0];
  assign w_b_zero = (bus.in_b == '0);
  assign w_ovf    = w_sdiv && (bus.in_a == MOST_NEG) && (bus.in_b == '1);
  assign w_fast   = (DIV_FASTPATH != 0) && (w_b_zero || w_ovf);
  // b==0 wins over overflow (b cannot be both 0 and -1)
  assign w_fast_res = w_b_zero ? (bus.in_op[1] ? bus.in_a : '1)
                               : (bus.in_op[1] ? '0 : bus.in_a);

  assign w_a_neg = w_sdiv && bus.in_a[XLEN-1];
  assign w_b_neg = w_sdiv && bus.in_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -bus.in_a : bus.in_a;
  assign w_b_mag = w_b_neg ? -bus.in_b : bus.in_b;

  // Extending both operands to 2*XLEN makes the truncated product exact
  // for every signedness mix.
  assign w_msa  = (bus.in_op[1:0] == 2'b01) || (bus.in_op[1:0] == 2'b10);
  assign w_msb  = (bus.in_op[1:0] == 2'b01);
  assign w_a_x  = {{XLEN{w_msa & bus.in_a[XLEN-1]}}, bus.in_a};
  assign w_b_x  = {{XLEN{w_msb & bus.in_b[XLEN-1]}}, bus.in_b};
  assign w_prod = w_a_x * w_b_x;

  function automatic logic [XLEN-1:0] f_mul_sel(input logic [2:0] op,
                                                input logic [PW-1:0] p);
    return (op == 3'b000) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // One restoring-division step
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_nx, w_q_nx, w_q_fix, w_r_fix, w_div_res;

  assign w_shift  = {r_rem, r_q[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  // a zero divisor always "fits": quotient all ones, remainder = dividend
  assign w_qbit   = ~w_diff[XLEN] | (r_dvs == '0);
  assign w_rem_nx = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_q_nx   = {r_q[XLEN-2:0], w_qbit};
  assign w_q_fix  = r_neg_q ? -w_q_nx : w_q_nx;
  assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; flush overrides everything
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (!w_is_div) w_next = (MUL_STAGES == 1) ? S_DONE : S_MUL;
          else           w_next = w_fast ? S_DONE : S_DIV;
        end
        S_MUL:  if (r_cnt == MUL_LAST) w_next = S_DONE;
        S_DIV:  if (r_cnt == DIV_LAST) w_next = S_DONE;
        S_DONE: if (bus.out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, multiply chain, divide iteration and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_prod   <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= bus.in_op;
          r_rd      <= bus.in_rd;
          r_cnt     <= '0;
          r_prod[0] <= w_prod;
          r_q       <= w_a_mag;
          r_rem     <= '0;
          r_dvs     <= w_b_mag;
          r_neg_q   <= w_sdiv && (w_a_neg ^ w_b_neg) && !w_b_zero;
          r_neg_r   <= w_a_neg;
          if (!w_is_div && MUL_STAGES == 1) r_result <= f_mul_sel(bus.in_op, w_prod);
          if (w_is_div && w_fast)           r_result <= w_fast_res;
        end
        S_MUL: begin
          for (int i = 1; i < PS; i++) r_prod[i] <= r_prod[i-1];
          if (r_cnt == MUL_LAST) begin
            r_result <= f_mul_sel(r_op, r_prod[PS-1]);
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_q   <= w_q_nx;
          r_rem <= w_rem_nx;
          if (r_cnt == DIV_LAST) begin
            r_result <= w_div_res;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE) && !bus.flush;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = r_result;
  assign bus.out_rd     = r_rd;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: two instances (divide fast path on / off) driven
// identically, checked every cycle against an arithmetic reference model.
module tb_ex_muldiv_unit;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_valid, t_flush, t_ordy;
  logic [2:0]  t_op;
  logic [31:0] t_a, t_b;
  logic [4:0]  t_rd;

  ex_muldiv_unit_if #(.XLEN(32)) b0 ();
  ex_muldiv_unit_if #(.XLEN(32)) b1 ();

  assign b0.in_valid = t_valid;  assign b1.in_valid = t_valid;
  assign b0.in_op    = t_op;     assign b1.in_op    = t_op;
  assign b0.in_a     = t_a;      assign b1.in_a     = t_a;
  assign b0.in_b     = t_b;      assign b1.in_b     = t_b;
  assign b0.in_rd    = t_rd;     assign b1.in_rd    = t_rd;
  assign b0.flush    = t_flush;  assign b1.flush    = t_flush;
  assign b0.out_ready = t_ordy;  assign b1.out_ready = t_ordy;

  ex_muldiv_unit #(.XLEN(32), .MUL_STAGES(MS), .DIV_FASTPATH(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  ex_muldiv_unit #(.XLEN(32), .MUL_STAGES(MS), .DIV_FASTPATH(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  logic [1:0]  o_valid, o_busy, o_ready;
  logic [31:0] o_res [2];
  logic [4:0]  o_rd  [2];
  assign o_valid = {b1.out_valid, b0.out_valid};
  assign o_busy  = {b1.busy, b0.busy};
  assign o_ready = {b1.in_ready, b0.in_ready};
  assign o_res[0] = b0.out_result;  assign o_res[1] = b1.out_result;
  assign o_rd[0]  = b0.out_rd;      assign o_rd[1]  = b1.out_rd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // edges from accept (accept edge counted as 1) until out_valid is seen
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit fp);
    if (!op[2]) return MS;
    if (fp && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  bit          m_act [2];
  int          m_cnt [2];
  int          m_lat [2];
  logic [31:0] m_res [2];
  logic [4:0]  m_rd  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 1'b0;
        m_cnt[d] = 0;
      end else if (t_flush) begin
        m_act[d] = 1'b0;
      end else if (m_act[d]) begin
        if (m_cnt[d] >= m_lat[d] && t_ordy) m_act[d] = 1'b0;
        else if (m_cnt[d] < m_lat[d])       m_cnt[d] = m_cnt[d] + 1;
      end else if (t_valid) begin
        m_act[d] = 1'b1;
        m_cnt[d] = 1;
        m_lat[d] = ref_lat(t_op, t_a, t_b, d == 0);
        m_res[d] = ref_res(t_op, t_a, t_b);
        m_rd[d]  = t_rd;
      end
    end
  end

  // Per-cycle comparison against the model
  logic ev;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev = m_act[d] && (m_cnt[d] >= m_lat[d]);
      chk($sformatf("d%0d out_valid", d), 32'(o_valid[d]), 32'(ev));
      chk($sformatf("d%0d busy", d), 32'(o_busy[d]), 32'(m_act[d]));
      chk($sformatf("d%0d in_ready", d), 32'(o_ready[d]), 32'(!m_act[d] && !t_flush));
      if (ev) begin
        chk($sformatf("d%0d out_result", d), o_res[d], m_res[d]);
        chk($sformatf("d%0d out_rd", d), 32'(o_rd[d]), 32'(m_rd[d]));
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat0, lat1;
  } vec_t;
  vec_t vt[$];

  task automatic run_vec(input vec_t v, input int idx);
    int n, l0, l1;
    logic [31:0] r0, r1;
    @(posedge clk); #1;
    t_valid = 1'b1; t_op = v.op; t_a = v.a; t_b = v.b; t_rd = 5'(idx + 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    chk($sformatf("v%0d model", idx), m_res[0], v.exp);
    n = 1; l0 = -1; l1 = -1; r0 = 'x; r1 = 'x;
    while ((l0 < 0 || l1 < 0) && n < 100) begin
      if (l0 < 0 && o_valid[0]) begin l0 = n; r0 = o_res[0]; end
      if (l1 < 0 && o_valid[1]) begin l1 = n; r1 = o_res[1]; end
      if (l0 < 0 || l1 < 0) begin @(posedge clk); #1; n++; end
    end
    chk($sformatf("v%0d lat fast", idx), l0, v.lat0);
    chk($sformatf("v%0d lat slow", idx), l1, v.lat1);
    chk($sformatf("v%0d res fast", idx), r0, v.exp);
    chk($sformatf("v%0d res slow", idx), r1, v.exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    t_valid = 0; t_flush = 0; t_ordy = 1; t_op = 0; t_a = 0; t_b = 0; t_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset out_result", o_res[d], 32'd0);
      chk("reset out_rd", 32'(o_rd[d]), 32'd0);
      chk("reset busy", 32'(o_busy[d]), 32'd0);
    end
    rst_n = 1'b1;

    vt.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 2});
    vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 2});
    vt.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 2});
    vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2});
    vt.push_back('{3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 2});
    vt.push_back('{3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25,        2, 2});
    vt.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 33, 33});
    vt.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE, 33, 33});
    vt.push_back('{3'd5, 32'd100,        32'd7,          32'd14,        33, 33});
    vt.push_back('{3'd7, 32'd100,        32'd7,          32'd2,         33, 33});
    vt.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33});
    vt.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 33});
    vt.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1, 33});
    vt.push_back('{3'd6, 32'd5,          32'd0,          32'd5,         1, 33});
    vt.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1, 33});
    vt.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1, 33});
    vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33});
    vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 33});
    nv = vt.size();
    for (int i = 0; i < nv; i++) run_vec(vt[i], i);

    // Backpressure: MUL result must hold while MEM stalls
    t_ordy = 1'b0;
    t_valid = 1'b1; t_op = 3'd0; t_a = 32'd6; t_b = 32'd7; t_rd = 5'd9;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp valid", 32'(o_valid[0]), 32'd1);
      chk("bp result", o_res[0], 32'd42);
      chk("bp rd", 32'(o_rd[0]), 32'd9);
      chk("bp busy", 32'(o_busy[0]), 32'd1);
      chk("bp in_ready", 32'(o_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    t_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp drain busy", 32'(o_busy[0]), 32'd0);
    chk("bp drain in_ready", 32'(o_ready[0]), 32'd1);

    // Flush at iteration 10 of a divide, with a new op offered the same cycle
    t_valid = 1'b1; t_op = 3'd5; t_a = 32'd100; t_b = 32'd7; t_rd = 5'd3;
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    t_flush = 1'b1; t_valid = 1'b1; t_op = 3'd0; t_a = 32'd2; t_b = 32'd3; t_rd = 5'd4;
    chk("flush in_ready", 32'(o_ready[1]), 32'd0);
    @(posedge clk); #1;
    t_flush = 1'b0; t_valid = 1'b0;
    chk("flush busy", 32'(o_busy[1]), 32'd0);
    chk("flush valid", 32'(o_valid[1]), 32'd0);
    begin
      int nval;
      nval = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (o_valid != 2'b00 || o_busy != 2'b00) nval++;
      end
      chk("flush no result", nval, 0);
    end

    // Asynchronous reset in the middle of a divide
    t_valid = 1'b1; t_op = 3'd4; t_a = 32'hFFFF_FFEC; t_b = 32'd3; t_rd = 5'd5;
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async rst valid", 32'(o_valid[d]), 32'd0);
      chk("async rst busy", 32'(o_busy[d]), 32'd0);
      chk("async rst result", o_res[d], 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One more op after reset to make sure the unit recovers
    run_vec(vt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
